// File: rtl/multiport_register_file.sv
// ============================================================================
// multiport_register_file
// ----------------------------------------------------------------------------
// Decode-stage register file for the pipelined MIPS datapath. It holds
// DEPTH = 2**ADDR_BITS registers of WIDTH bits. Register 0 always reads zero.
// The block has READ_PORTS independent combinational read ports and one
// synchronous write port. It also contains:
//   * a per-register pending-write scoreboard, which the hazard unit sets with
//     Reserve and which a write to the same register clears;
//   * a soft-clear engine. It sweeps registers 1..DEPTH-1 to zero, one per
//     clock, then gives a one-cycle done pulse.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a write in flight is forwarded to any read port that
//               addresses the same register in the same cycle (write-through).
//               That port's Busy bit also shows the clear that the write
//               performs.
//   undefined - reads return stored contents only.
//
// Parameters
//   WIDTH       data width of every register
//   ADDR_BITS   register address width (DEPTH = 2**ADDR_BITS)
//   READ_PORTS  number of read ports (1..4)
//
// Ports
//   Clk             in   rising-edge clock
//   Reset           in   asynchronous, active-high; clears all state
//   RegWrite        in   write strobe
//   WriteRegister   in   write address
//   WriteData       in   write data
//   ReadRegister    in   read addresses; port i at [i*ADDR_BITS +: ADDR_BITS]
//   ReadData        out  read data; port i at [i*WIDTH +: WIDTH]
//   Reserve         in   marks ReserveRegister as pending-write
//   ReserveRegister in   register to reserve
//   Busy            out  bit i = scoreboard bit of read port i's register
//   ClearReq        in   request a soft clear of registers 1..DEPTH-1
//   ClearBusy       out  high while the clear sweep runs
//   ClearDone       out  one-cycle pulse when the sweep completes
// ============================================================================
module multiport_register_file #(
    parameter int WIDTH      = 32,
    parameter int ADDR_BITS  = 5,
    parameter int READ_PORTS = 2
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             RegWrite,
    input  logic [ADDR_BITS-1:0]             WriteRegister,
    input  logic [WIDTH-1:0]                 WriteData,
    input  logic [READ_PORTS*ADDR_BITS-1:0]  ReadRegister,
    output logic [READ_PORTS*WIDTH-1:0]      ReadData,
    input  logic                             Reserve,
    input  logic [ADDR_BITS-1:0]             ReserveRegister,
    output logic [READ_PORTS-1:0]            Busy,
    input  logic                             ClearReq,
    output logic                             ClearBusy,
    output logic                             ClearDone
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Highest register index. The sweep finishes after it zeroes this entry.
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] FIRST_IDX = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ZERO_IDX  = '0;

    // Clear-engine states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [ADDR_BITS-1:0] idx_q;
    logic [ADDR_BITS-1:0] idx_d;

    // ------------------------------------------------------------------
    // Qualified write / reserve strobes
    // ------------------------------------------------------------------
    // The sweep owns the array. Writes and reserves that arrive during the
    // sweep are dropped, not queued. Index 0 is never a real target.
    logic sweeping;
    logic wr_en;
    logic rsv_en;
    logic clear_all;

    assign sweeping = (state_q == ST_SWEEP);
    assign wr_en    = RegWrite && (WriteRegister   != ZERO_IDX) && !sweeping;
    assign rsv_en   = Reserve  && (ReserveRegister != ZERO_IDX) && !sweeping;

    // ------------------------------------------------------------------
    // Clear FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block. An assignment missing on some path would otherwise
    // infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clear_all = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    state_d   = ST_SWEEP;
                    idx_d     = FIRST_IDX;
                    clear_all = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + FIRST_IDX;
                end
            end
            ST_DONE: begin
                // ClearReq is ignored here. A held request restarts from IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample their inputs at the same instant, whatever order the
    // blocks are evaluated in.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign ClearBusy = (state_q == ST_SWEEP);
    assign ClearDone = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // The write clear is applied first and the reserve set afterwards, so a
    // same-cycle reserve of the same register keeps it busy. Starting a
    // sweep invalidates every pending write, so clear_all has priority.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[WriteRegister] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[ReserveRegister] = 1'b1;
        end
        if (clear_all) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    // NOTE: this array is deliberately reset, because software relies on
    // every register reading zero after Reset. A storage array with no
    // architectural reset value would leave out the reset branch, so that
    // it could map onto RAM.
    // Entry 0 is reset and never written, so it stays a constant zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (sweeping) begin
            regs_q[idx_q] <= '0;
        end else if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_BITS-1:0] addr;
        logic [WIDTH-1:0]     data;
        logic                 busy_bit;

        assign addr = ReadRegister[p*ADDR_BITS +: ADDR_BITS];

        always_comb begin
            data     = regs_q[addr];
            busy_bit = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write. The busy bit drops with it unless
            // a reserve of the same register re-sets it at this edge.
            if (wr_en && (WriteRegister == addr)) begin
                data = WriteData;
                if (!(rsv_en && (ReserveRegister == WriteRegister))) begin
                    busy_bit = 1'b0;
                end
            end
`endif
        end

        assign ReadData[p*WIDTH +: WIDTH] = data;
        assign Busy[p]                    = busy_bit;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file.
// The stimulus driver predicts each cycle's outputs from a time-based
// reference model and queues the prediction. A negedge monitor pops each
// prediction and compares it with the DUT. A second, small instance
// (WIDTH=16, ADDR_BITS=3, READ_PORTS=3) gets directed checks at the end.
module tb_multiport_register_file;

    localparam int W     = 32;
    localparam int AB    = 5;
    localparam int RP    = 2;
    localparam int DEPTH = 2 ** AB;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            RegWrite;
    logic [AB-1:0]   WriteRegister;
    logic [W-1:0]    WriteData;
    logic [RP*AB-1:0] ReadRegister;
    logic [RP*W-1:0] ReadData;
    logic            Reserve;
    logic [AB-1:0]   ReserveRegister;
    logic [RP-1:0]   Busy;
    logic            ClearReq;
    logic            ClearBusy;
    logic            ClearDone;

    always #5 Clk = ~Clk;

    multiport_register_file #(.WIDTH(W), .ADDR_BITS(AB), .READ_PORTS(RP)) dut (
        .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(ReadData),
        .Reserve(Reserve), .ReserveRegister(ReserveRegister), .Busy(Busy),
        .ClearReq(ClearReq), .ClearBusy(ClearBusy), .ClearDone(ClearDone)
    );

    // Small configuration
    logic        s_RegWrite = 1'b0;
    logic [2:0]  s_WriteRegister = '0;
    logic [15:0] s_WriteData = '0;
    logic [8:0]  s_ReadRegister = '0;
    logic [47:0] s_ReadData;
    logic        s_Reserve = 1'b0;
    logic [2:0]  s_ReserveRegister = '0;
    logic [2:0]  s_Busy;
    logic        s_ClearReq = 1'b0;
    logic        s_ClearBusy;
    logic        s_ClearDone;

    multiport_register_file #(.WIDTH(16), .ADDR_BITS(3), .READ_PORTS(3)) dut_small (
        .Clk(Clk), .Reset(Reset), .RegWrite(s_RegWrite), .WriteRegister(s_WriteRegister),
        .WriteData(s_WriteData), .ReadRegister(s_ReadRegister), .ReadData(s_ReadData),
        .Reserve(s_Reserve), .ReserveRegister(s_ReserveRegister), .Busy(s_Busy),
        .ClearReq(s_ClearReq), .ClearBusy(s_ClearBusy), .ClearDone(s_ClearDone)
    );

    typedef struct packed {
        logic          rw;
        logic [AB-1:0] wa;
        logic [W-1:0]  wd;
        logic          rsv;
        logic [AB-1:0] ra;
        logic          clr;
        logic [RP*AB-1:0] rd;
    } stim_t;

    typedef struct packed {
        logic [31:0]     tag;
        logic [RP*W-1:0] data;
        logic [RP-1:0]   busy;
        logic            cb;
        logic            cd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // ---------------- reference model ----------------
    logic [W-1:0] m_mem [DEPTH];
    bit           m_busy [DEPTH];
    int           m_since;   // edges since a ClearReq was accepted; -1 = no clear activity
    bit           m_rst;
    stim_t        cur;

    function automatic bit m_sweeping();
        return (m_since >= 0) && (m_since < DEPTH - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_since = -1;
    endtask

    // Apply one rising edge using the inputs held during the previous cycle.
    // A clear accepted at edge k zeroes register j at edge k+j, for j = 1..DEPTH-1.
    task automatic model_edge();
        if (m_rst) return;
        if (m_sweeping()) begin
            m_mem[m_since + 1] = '0;
            m_since++;
        end else begin
            bit was_done;
            was_done = (m_since == DEPTH - 1);
            if (cur.rw && cur.wa != 0) begin
                m_mem[cur.wa]  = cur.wd;
                m_busy[cur.wa] = 1'b0;
            end
            if (cur.rsv && cur.ra != 0) m_busy[cur.ra] = 1'b1;
            if (was_done) begin
                m_since = -1;
            end else if (cur.clr) begin
                m_since = 0;
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end
        end
    endtask

    task automatic expect_now();
        exp_t e;
        e.tag  = 32'(cyc);
        e.cb   = m_sweeping();
        e.cd   = (m_since == DEPTH - 1);
        e.data = '0;
        e.busy = '0;
        for (int p = 0; p < RP; p++) begin
            logic [AB-1:0] a;
            logic [W-1:0]  d;
            bit            b;
            a = cur.rd[p*AB +: AB];
            d = (a == 0) ? '0 : m_mem[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (cur.rw && cur.wa != 0 && cur.wa == a && !m_sweeping()) begin
                d = cur.wd;
                if (!(cur.rsv && cur.ra == cur.wa)) b = 1'b0;
            end
`endif
            e.data[p*W +: W] = d;
            e.busy[p]        = b;
        end
        sb_q.push_back(e);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string what, input int tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", what, tag, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("ReadData",  int'(e.tag), 64'(ReadData),  64'(e.data));
            check("Busy",      int'(e.tag), 64'(Busy),      64'(e.busy));
            check("ClearBusy", int'(e.tag), 64'(ClearBusy), 64'(e.cb));
            check("ClearDone", int'(e.tag), 64'(ClearDone), 64'(e.cd));
        end
    end

    // ---------------- driving ----------------
    task automatic drive(input stim_t s);
        RegWrite        = s.rw;
        WriteRegister   = s.wa;
        WriteData       = s.wd;
        Reserve         = s.rsv;
        ReserveRegister = s.ra;
        ClearReq        = s.clr;
        ReadRegister    = s.rd;
    endtask

    task automatic step(input stim_t s);
        @(posedge Clk);
        model_edge();
        #1;
        drive(s);
        cur = s;
        cyc++;
        expect_now();
    endtask

    // Reset is raised 1 time unit after an edge and held for n further edges.
    task automatic do_reset(input int n);
        @(posedge Clk);
        model_edge();
        #1;
        Reset = 1'b1;
        m_rst = 1'b1;
        model_reset();
        cur = '0;
        drive(cur);
        cyc++;
        expect_now();
        repeat (n) begin
            @(posedge Clk);
            #1;
            cyc++;
            expect_now();
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        m_rst = 1'b0;
        cyc++;
        expect_now();
    endtask

    function automatic stim_t idle_rd(input int a0, input int a1);
        stim_t s;
        s = '0;
        s.rd = {AB'(a1), AB'(a0)};
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        int    cnt;
        cur = '0;
        drive(cur);
        m_rst = 1'b1;
        model_reset();

        do_reset(2);

        // Every address reads zero after reset
        for (int a = 0; a < DEPTH; a++) step(idle_rd(a, DEPTH - 1 - a));

        // Write r5, attempt r0
        s = idle_rd(5, 0); s.rw = 1; s.wa = 5; s.wd = 32'hDEADBEEF; step(s);
        s = idle_rd(5, 0); s.rw = 1; s.wa = 0; s.wd = 32'h12345678; step(s);
        step(idle_rd(5, 0));

        // Scoreboard: reserve, same-cycle reserve+write, later write
        s = idle_rd(7, 7); s.rsv = 1; s.ra = 7; step(s);
        step(idle_rd(7, 0));
        s = idle_rd(7, 7); s.rsv = 1; s.ra = 7; s.rw = 1; s.wa = 7; s.wd = 32'h1; step(s);
        step(idle_rd(7, 7));
        s = idle_rd(7, 7); s.rw = 1; s.wa = 7; s.wd = 32'h2; step(s);
        step(idle_rd(7, 7));
        s = idle_rd(0, 0); s.rsv = 1; s.ra = 0; step(s);
        step(idle_rd(0, 7));

        // Fill r1..r31 with index values, then a one-cycle clear with a dropped write
        for (int i = 1; i < DEPTH; i++) begin
            s = idle_rd(i, i - 1); s.rw = 1; s.wa = AB'(i); s.wd = 32'(i); step(s);
        end
        s = idle_rd(3, 31); s.rsv = 1; s.ra = 9; step(s);
        s = idle_rd(3, 31); s.clr = 1; step(s);
        for (int j = 0; j < 40; j++) begin
            s = idle_rd(j % DEPTH, 3);
            if (j == 5) begin s.rw = 1; s.wa = 3; s.wd = 32'hFF; s.rsv = 1; s.ra = 4; end
            step(s);
        end
        for (int a = 0; a < DEPTH; a++) step(idle_rd(a, 9));

        // Reset at sweep cycle 10 while r20 is still unswept
        s = idle_rd(20, 0); s.rw = 1; s.wa = 20; s.wd = 32'h55; step(s);
        s = idle_rd(20, 1); s.clr = 1; step(s);
        for (int j = 0; j < 9; j++) step(idle_rd(20, j + 1));
        do_reset(1);
        for (int j = 0; j < 40; j++) step(idle_rd(20, 1));

        // ClearReq held continuously: back-to-back sweeps
        for (int j = 0; j < 75; j++) begin
            s = idle_rd(j % DEPTH, (j * 7) % DEPTH); s.clr = 1;
            s.rw = 1; s.wa = AB'(j); s.wd = 32'(j * 3 + 1);
            step(s);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s.rw  = 1'($urandom_range(0, 1));
            s.wa  = AB'($urandom);
            s.wd  = $urandom;
            s.rsv = ($urandom_range(0, 3) == 0);
            s.ra  = ($urandom_range(0, 3) == 0) ? s.wa : AB'($urandom);
            s.clr = ($urandom_range(0, 59) == 0);
            s.rd  = RP*AB'($urandom);
            if ($urandom_range(0, 2) == 0) s.rd[AB-1:0] = s.wa;
            if ($urandom_range(0, 699) == 0) do_reset(1);
            else step(s);
        end

        // Let the monitor consume the last prediction
        s = '0;
        @(posedge Clk);
        #1;
        drive(s);
        @(negedge Clk);
        #1;
        check("scoreboard_drain", cyc, 64'(sb_q.size()), 64'd0);

        // Small configuration: WIDTH=16, ADDR_BITS=3, READ_PORTS=3
        @(posedge Clk);
        #1;
        s_RegWrite = 1'b1; s_WriteRegister = 3'd7; s_WriteData = 16'hA5A5;
        s_ReadRegister = {3'd7, 3'd7, 3'd7};
        @(posedge Clk);
        #1;
        s_RegWrite = 1'b0;
        for (int p = 0; p < 3; p++) check("small_read_r7", p, 64'(s_ReadData[p*16 +: 16]), 64'hA5A5);
        check("small_idle_busy", cyc, 64'(s_ClearBusy), 64'd0);
        s_ClearReq = 1'b1;
        @(posedge Clk);
        #1;
        s_ClearReq = 1'b0;
        cnt = 0;
        while (s_ClearBusy && cnt < 64) begin
            cnt++;
            @(posedge Clk);
            #1;
        end
        check("small_sweep_len", cyc, 64'(cnt), 64'd7);
        check("small_done_pulse", cyc, 64'(s_ClearDone), 64'd1);
        @(posedge Clk);
        #1;
        check("small_done_width", cyc, 64'(s_ClearDone), 64'd0);
        check("small_r7_cleared", cyc, 64'(s_ReadData[15:0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
